spart_echo_driver: RTL and testbench



---
 rtl/spart_echo_driver_if.sv | 12 +
 rtl/spart_echo_driver.sv | 209 ++++++++++++++++++++
 tb/tb_spart_echo_driver.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_echo_driver_if.sv
// SPART processor-side control bus: strobes and address out, status flags in.
// The 8-bit tri-state data bus stays a plain inout port on the driver.
interface spart_echo_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_echo_driver.sv
// SPART host driver: programs the baud divisor selected by br_cfg, then echoes
// received bytes back through a circular buffer, optionally upper-casing them.
// Bus strobes are registered on the transition into the state that owns them,
// so every access is visible for exactly one cycle.
module spart_echo_driver #(
    parameter int DIV0         = 651,
    parameter int DIV1         = 326,
    parameter int DIV2         = 163,
    parameter int DIV3         = 81,
    parameter int DIV_W        = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int UPCASE       = 0,
    parameter int DROP_ON_FULL = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  br_cfg,
    spart_echo_driver_if.master         bus,
    inout  wire  [7:0]                  databus,
    output logic                        cfg_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ADDR_DATA  = 2'b00;
    localparam logic [1:0] ADDR_DB_LO = 2'b10;
    localparam logic [1:0] ADDR_DB_HI = 2'b11;

    typedef enum logic [2:0] {
        CFG_LO_WAIT,
        CFG_LO,
        CFG_HI_WAIT,
        CFG_HI,
        RUN,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       br_cfg_q;
    logic             reconfig;
    logic [DIV_W-1:0] div;
    logic [7:0]       div_lo;
    logic [7:0]       div_hi;

    logic             iocs_q,   iocs_nxt;
    logic             iorw_q,   iorw_nxt;
    logic [1:0]       ioaddr_q, ioaddr_nxt;
    logic [7:0]       data_q,   data_nxt;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_read;
    logic             do_write;
    logic             rd_strobe;
    logic             wr_strobe;
    logic             push;
    logic             pop;
    logic             drop;

    function automatic logic [7:0] tx_map(input logic [7:0] b);
        if (UPCASE != 0 && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    // A change on the baud switches restarts everything from configuration.
    assign reconfig = (br_cfg != br_cfg_q);

    // Divisor lookup from the registered baud select.
    always_comb begin
        case (br_cfg_q)
            2'b00:   div = DIV_W'(DIV0);
            2'b01:   div = DIV_W'(DIV1);
            2'b10:   div = DIV_W'(DIV2);
            default: div = DIV_W'(DIV3);
        endcase
    end

    assign div_lo = div[7:0];
    assign div_hi = 8'(div >> 8);

    assign full     = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign empty    = (fifo_count == '0);
    assign do_read  = bus.rda && (!full || DROP_ON_FULL != 0);
    assign do_write = !do_read && bus.tbr && !empty;

    // The strobe on the bus this cycle completes at the edge that ends it.
    assign rd_strobe = iocs_q && iorw_q && (ioaddr_q == ADDR_DATA);
    assign wr_strobe = iocs_q && !iorw_q && (ioaddr_q == ADDR_DATA);
    assign push      = rd_strobe && !full;
    assign drop      = rd_strobe && full;
    assign pop       = wr_strobe;

    // State register and registered copy of the baud select.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CFG_LO_WAIT;
            br_cfg_q <= br_cfg;
        end else begin
            state    <= state_nxt;
            br_cfg_q <= br_cfg;
        end
    end

    // Next-state logic; a baud change overrides every transition.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            CFG_LO_WAIT: if (bus.tbr) state_nxt = CFG_LO;
            CFG_LO:      state_nxt = CFG_HI_WAIT;
            CFG_HI_WAIT: if (bus.tbr) state_nxt = CFG_HI;
            CFG_HI:      state_nxt = RUN;
            RUN:         if (do_read || do_write) state_nxt = GAP;
            GAP:         state_nxt = RUN;
            default:     state_nxt = CFG_LO_WAIT;
        endcase
        if (reconfig) state_nxt = CFG_LO_WAIT;
    end

    // Bus access to present next cycle, decided from the transition being taken.
    always_comb begin
        iocs_nxt   = 1'b0;
        iorw_nxt   = 1'b1;
        ioaddr_nxt = ADDR_DATA;
        data_nxt   = 8'h00;
        if (!reconfig) begin
            case (state)
                CFG_LO_WAIT: if (bus.tbr) begin
                    iocs_nxt   = 1'b1;
                    iorw_nxt   = 1'b0;
                    ioaddr_nxt = ADDR_DB_LO;
                    data_nxt   = div_lo;
                end
                CFG_HI_WAIT: if (bus.tbr) begin
                    iocs_nxt   = 1'b1;
                    iorw_nxt   = 1'b0;
                    ioaddr_nxt = ADDR_DB_HI;
                    data_nxt   = div_hi;
                end
                RUN: if (do_read) begin
                    iocs_nxt   = 1'b1;
                end else if (do_write) begin
                    iocs_nxt   = 1'b1;
                    iorw_nxt   = 1'b0;
                    data_nxt   = tx_map(mem[rd_ptr]);
                end
                default: ;
            endcase
        end
    end

    // Registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            iocs_q   <= 1'b0;
            iorw_q   <= 1'b1;
            ioaddr_q <= ADDR_DATA;
            data_q   <= 8'h00;
        end else begin
            iocs_q   <= iocs_nxt;
            iorw_q   <= iorw_nxt;
            ioaddr_q <= ioaddr_nxt;
            data_q   <= data_nxt;
        end
    end

    assign bus.iocs   = iocs_q;
    assign bus.iorw   = iorw_q;
    assign bus.ioaddr = ioaddr_q;
    assign databus    = (iocs_q && !iorw_q) ? data_q : 8'hzz;

    // Buffer pointers, occupancy and sticky overflow; a baud change flushes them.
    always_ff @(posedge clk) begin
        if (rst || reconfig) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                fifo_count <= fifo_count - CNT_W'(1);
            end
            if (drop) overflow <= 1'b1;
        end
    end

    // Buffer storage, captured from the data bus at the end of a read strobe.
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= databus;
    end

    // Echo loop becomes active on the edge that ends the high-byte write.
    always_ff @(posedge clk) begin
        if (rst || reconfig)    cfg_done <= 1'b0;
        else if (state == CFG_HI) cfg_done <= 1'b1;
    end
endmodule

// File: tb/tb_spart_echo_driver.sv
// Bench for spart_echo_driver: two instances (plain/drop and upcase/backpressure)
// each attached to a queue-based SPART model; transmitted bytes are compared
// against the received stream mapped by the echo rules.
module tb_spart_echo_driver;
    localparam int N_RAND = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] br_cfg;

    spart_echo_driver_if bus0 ();
    spart_echo_driver_if bus1 ();

    wire  [7:0] db0;
    wire  [7:0] db1;
    logic [7:0] rx_data0 = 8'h00;
    logic [7:0] rx_data1 = 8'h00;
    logic       cfg_done0, cfg_done1, overflow0, overflow1;
    logic [3:0] fifo_count0, fifo_count1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rxq0[$], rxq1[$], txq0[$], txq1[$], exp0[$], exp1[$];
    int         rd_cyc0[$], rd_cyc1[$], wr_cyc0[$], wr_cyc1[$];
    bit         pop_pend0 = 1'b0;
    bit         pop_pend1 = 1'b0;
    int         div_tab [4] = '{651, 326, 163, 81};

    // The SPART drives data whenever the driver is not writing.
    assign db0 = (bus0.iocs && !bus0.iorw) ? 8'hzz : rx_data0;
    assign db1 = (bus1.iocs && !bus1.iorw) ? 8'hzz : rx_data1;

    spart_echo_driver #(.UPCASE(0), .DROP_ON_FULL(1)) dut0 (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .bus(bus0), .databus(db0),
        .cfg_done(cfg_done0), .fifo_count(fifo_count0), .overflow(overflow0)
    );

    spart_echo_driver #(.UPCASE(1), .DROP_ON_FULL(0)) dut1 (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .bus(bus1), .databus(db1),
        .cfg_done(cfg_done1), .fifo_count(fifo_count1), .overflow(overflow1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // SPART model for instance 0: a byte leaves the receive queue after its read strobe.
    always @(posedge clk) begin
        #1;
        if (pop_pend0 && rxq0.size() > 0) void'(rxq0.pop_front());
        pop_pend0 = 1'b0;
        if (bus0.iocs && bus0.iorw && bus0.ioaddr == 2'b00) begin
            pop_pend0 = 1'b1;
            rd_cyc0.push_back(cyc);
        end
        if (bus0.iocs && !bus0.iorw && bus0.ioaddr == 2'b00) begin
            txq0.push_back(db0);
            wr_cyc0.push_back(cyc);
        end
        bus0.rda = (rxq0.size() > 0);
        rx_data0 = (rxq0.size() > 0) ? rxq0[0] : 8'h00;
    end

    // SPART model for instance 1.
    always @(posedge clk) begin
        #1;
        if (pop_pend1 && rxq1.size() > 0) void'(rxq1.pop_front());
        pop_pend1 = 1'b0;
        if (bus1.iocs && bus1.iorw && bus1.ioaddr == 2'b00) begin
            pop_pend1 = 1'b1;
            rd_cyc1.push_back(cyc);
        end
        if (bus1.iocs && !bus1.iorw && bus1.ioaddr == 2'b00) begin
            txq1.push_back(db1);
            wr_cyc1.push_back(cyc);
        end
        bus1.rda = (rxq1.size() > 0);
        rx_data1 = (rxq1.size() > 0) ? rxq1[0] : 8'h00;
    end

    function automatic logic [7:0] up(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        rd_cyc0.delete(); wr_cyc0.delete(); txq0.delete(); exp0.delete();
        rd_cyc1.delete(); wr_cyc1.delete(); txq1.delete(); exp1.delete();
    endtask

    // Walks the four configuration cycles, starting one edge before CFG_LO.
    task automatic cfg_seq(input int sel, input string tag);
        int d = div_tab[sel];
        tick();
        check({tag, "_lo"}, {bus0.iocs, bus0.iorw, bus0.ioaddr, db0, cfg_done0},
              {1'b1, 1'b0, 2'b10, 8'(d % 256), 1'b0});
        tick();
        check({tag, "_wait"}, {bus0.iocs, cfg_done0}, 2'b00);
        tick();
        check({tag, "_hi"}, {bus0.iocs, bus0.iorw, bus0.ioaddr, db0, cfg_done0},
              {1'b1, 1'b0, 2'b11, 8'(d / 256), 1'b0});
        tick();
        check({tag, "_done"}, {bus0.iocs, cfg_done0, cfg_done1}, 3'b011);
    endtask

    initial begin
        logic [7:0] b;
        int         sent0;
        int         sent1;
        bit         found;

        // Reset and first configuration (br_cfg = 01 -> divisor 326).
        rst       = 1'b1;
        br_cfg    = 2'b01;
        bus0.tbr  = 1'b1;
        bus1.tbr  = 1'b1;
        repeat (3) tick();
        check("reset_state", {bus0.iocs, bus0.iorw, bus0.ioaddr, cfg_done0, fifo_count0, overflow0},
              {1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0});
        @(negedge clk) rst = 1'b0;
        cfg_seq(1, "cfg1");

        // Single-byte echo latency on instance 0, case mapping on instance 1.
        @(negedge clk);
        clear_logs();
        rxq0.push_back(8'h41);
        foreach (rxq1[i]) ;
        rxq1.push_back(8'h60); rxq1.push_back(8'h61); rxq1.push_back(8'h7A); rxq1.push_back(8'h7B);
        exp1.push_back(up(8'h60)); exp1.push_back(up(8'h61));
        exp1.push_back(up(8'h7A)); exp1.push_back(up(8'h7B));
        repeat (30) tick();
        check("lat_reads",  rd_cyc0.size(), 1);
        check("lat_writes", wr_cyc0.size(), 1);
        check("lat_gap", (rd_cyc0.size() > 0 && wr_cyc0.size() > 0) ? wr_cyc0[0] - rd_cyc0[0] : -1, 2);
        check("lat_data", (txq0.size() > 0) ? txq0[0] : 8'hxx, 8'h41);
        check("lat_count", fifo_count0, 4'd0);
        check("up_len", txq1.size(), 4);
        for (int i = 0; i < 4; i++)
            check("up_data", (i < txq1.size()) ? txq1[i] : 8'hxx, exp1[i]);

        // Random paced stream with random transmitter readiness; no overflow possible.
        @(negedge clk);
        clear_logs();
        sent0 = 0;
        sent1 = 0;
        for (int c = 0; c < 4000 && (txq0.size() < N_RAND || txq1.size() < N_RAND); c++) begin
            @(negedge clk);
            bus0.tbr = ($urandom_range(3) != 0);
            bus1.tbr = ($urandom_range(1) != 0);
            if (sent0 < N_RAND && rxq0.size() == 0 && (rd_cyc0.size() - txq0.size()) < 4
                && $urandom_range(1) != 0) begin
                b = 8'($urandom);
                rxq0.push_back(b);
                exp0.push_back(b);
                sent0++;
            end
            if (sent1 < N_RAND && rxq1.size() == 0 && (rd_cyc1.size() - txq1.size()) < 4
                && $urandom_range(1) != 0) begin
                b = 8'($urandom);
                rxq1.push_back(b);
                exp1.push_back(up(b));
                sent1++;
            end
        end
        check("rand0_len", txq0.size(), N_RAND);
        check("rand1_len", txq1.size(), N_RAND);
        for (int i = 0; i < N_RAND; i++) begin
            check("rand0_data", (i < txq0.size() && i < exp0.size()) ? txq0[i] : 8'hxx,
                  (i < exp0.size()) ? exp0[i] : 8'h00);
            check("rand1_data", (i < txq1.size() && i < exp1.size()) ? txq1[i] : 8'hxx,
                  (i < exp1.size()) ? exp1[i] : 8'h00);
        end
        check("rand_ovf", {overflow0, overflow1}, 2'b00);

        // Nine bytes with the transmitter blocked: drop on instance 0, backpressure on instance 1.
        @(negedge clk);
        clear_logs();
        bus0.tbr = 1'b0;
        bus1.tbr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            rxq0.push_back(b);
            rxq1.push_back(b);
            if (i < 8) exp0.push_back(b);
            exp1.push_back(up(b));
        end
        repeat (40) tick();
        check("full0_count", fifo_count0, 4'd8);
        check("full0_ovf",   overflow0, 1'b1);
        check("full0_reads", rd_cyc0.size(), 9);
        check("full1_count", fifo_count1, 4'd8);
        check("full1_ovf",   overflow1, 1'b0);
        check("full1_left",  rxq1.size(), 1);
        repeat (20) tick();
        check("bp_no_read",  rd_cyc1.size(), 8);
        @(negedge clk);
        bus0.tbr = 1'b1;
        bus1.tbr = 1'b1;
        repeat (60) tick();
        check("drain0_len", txq0.size(), 8);
        check("drain1_len", txq1.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < 8)
                check("drain0_data", (i < txq0.size()) ? txq0[i] : 8'hxx, exp0[i]);
            check("drain1_data", (i < txq1.size()) ? txq1[i] : 8'hxx, exp1[i]);
        end
        check("drain_count", {fifo_count0, fifo_count1}, 8'h00);
        check("ovf_sticky", overflow0, 1'b1);

        // Baud change to 00, then to 11 while waiting for the high byte.
        @(negedge clk) br_cfg = 2'b00;
        tick();
        check("recfg_clear", {bus0.iocs, cfg_done0, overflow0, fifo_count0}, 7'd0);
        tick();
        check("recfg0_lo", {bus0.iocs, bus0.iorw, bus0.ioaddr, db0},
              {1'b1, 1'b0, 2'b10, 8'(div_tab[0] % 256)});
        tick();
        check("recfg0_wait", bus0.iocs, 1'b0);
        @(negedge clk) br_cfg = 2'b11;
        tick();
        check("hi_suppressed", {bus0.iocs, cfg_done0}, 2'b00);
        cfg_seq(3, "cfg3");

        // Baud change with three bytes buffered and a write about to be issued.
        @(negedge clk);
        clear_logs();
        bus0.tbr = 1'b0;
        rxq0.push_back(8'h31); rxq0.push_back(8'h32); rxq0.push_back(8'h33);
        repeat (12) tick();
        check("buf3_count", fifo_count0, 4'd3);
        @(negedge clk);
        br_cfg   = 2'b10;
        bus0.tbr = 1'b1;
        tick();
        check("flush", {bus0.iocs, fifo_count0, cfg_done0}, 6'd0);
        cfg_seq(2, "cfg2");
        repeat (10) tick();
        check("flush_no_tx", txq0.size(), 0);

        // Reset asserted during a write strobe.
        @(negedge clk) rxq0.push_back(8'h55);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = bus0.iocs && !bus0.iorw && bus0.ioaddr == 2'b00;
        end
        check("rst_wr_seen", found, 1'b1);
        check("rst_wr_data", db0, 8'h55);
        @(negedge clk) rst = 1'b1;
        tick();
        check("rst_mid", {bus0.iocs, bus0.iorw, bus0.ioaddr, cfg_done0, fifo_count0, overflow0, cfg_done1},
              {1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0});
        @(negedge clk) rst = 1'b0;
        cfg_seq(2, "rst_cfg");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
